histogram_engine: RTL and testbench
===================================

Name: histogram_engine

Overview:
Parametrised successor to the camera-side 10-bit histogram/SPI path. Accumulates a per-frame histogram of PIXEL_W-bit pixels into NUM_BINS saturating counters (block RAM, read-modify-write). After frame end, streams the bins over a valid/ready interface to a downstream serializer or FIFO. Each bin is cleared as it is read, so the engine is ready for the next frame without a separate clear pass.

Parameters:
PIXEL_W, 10, pixel width in bits
BIN_BITS, 10, log2(NUM_BINS); NUM_BINS = 2**BIN_BITS; must satisfy BIN_BITS <= PIXEL_W
COUNT_W, 24, bin counter width; counters saturate at 2**COUNT_W-1

Ports:
clk  in  1  single system clock
reset  in  1  asynchronous, active-high reset
pixel_data  in  PIXEL_W  pixel sample
frame_valid  in  1  high for the whole frame
line_valid  in  1  pixel qualifier; a pixel counts only when frame_valid && line_valid
out_data  out  COUNT_W  bin count
out_bin  out  BIN_BITS  bin index of out_data
out_valid  out  1  readout word valid
out_ready  in  1  downstream accept; transfer = out_valid && out_ready
out_last  out  1  high on the final word of a frame's readout
busy  out  1  high in any state except IDLE
frame_dropped  out  1  one-cycle pulse when a frame is ignored
sat_flag  out  1  sticky per frame: some bin saturated; valid during READOUT, cleared on entry to ACCUM

Behaviour:
- Reset (async assert, sync deassert inside the block): state=INIT; out_valid=0, out_last=0, out_data=0, out_bin=0, busy=1, frame_dropped=0, sat_flag=0.
- INIT: writes 0 to every RAM address, one per cycle (NUM_BINS cycles), then goes to IDLE. A reset mid-operation always returns to INIT, so the RAM is never trusted after reset.
- IDLE: rising edge of frame_valid (0 in previous cycle, 1 now) -> ACCUM. If frame_valid is already high on INIT exit, wait for the next rising edge. Mid-frame data is never counted.
- ACCUM: bin = pixel_data[PIXEL_W-1 -: BIN_BITS]. Each qualified pixel adds 1 to its bin.
  - One pixel per clock, back-to-back, with any bin sequence, including identical consecutive bins.
  - Counts must be exact; same-bin hazards are resolved by forwarding or coalescing. No stall input exists.
  - Counter at max stays at max and sets sat_flag.
  - frame_valid falling -> DRAIN.
- DRAIN: exactly 2 cycles to retire the pipeline, then READOUT.
- READOUT: presents bins 0..NUM_BINS-1 in order.
  - out_valid rises on the first READOUT cycle (first word <= 3 cycles after the fall edge of frame_valid).
  - out_data, out_bin and out_last hold stable while out_valid && !out_ready.
  - On each transfer the bin's RAM entry is written to 0.
  - Next word follows on the cycle after a transfer (full throughput when out_ready is held high).
  - out_last=1 with bin NUM_BINS-1 (or the trailer when HISTO_SUM_EN is defined); transfer of the last word -> IDLE, out_valid=0.
- Frame during DRAIN/READOUT/INIT: pixels ignored, frame_dropped pulses once on its frame_valid rising edge, readout continues unaffected.
- frame_valid rising and readout last transfer in the same cycle: the frame is dropped (IDLE requires an edge).
- An empty frame (no line_valid) still produces a full readout of zeros.

Optional Feature:
Macro HISTO_SUM_EN.
- Defined: one trailer word follows bin NUM_BINS-1; out_bin = all ones, out_data = total qualified pixel count of the frame (COUNT_W wide, saturating), out_last on the trailer only. Readout = NUM_BINS+1 words.
- Undefined: no trailer, no total counter logic; readout = NUM_BINS words, out_last on bin NUM_BINS-1.

Test Plan:
- Reset, wait NUM_BINS cycles, frame of 16 pixels all 0x000, out_ready=1 -> bin0=16, all other bins 0, out_last on bin 1023, busy low after.
- Frame of 1024 pixels ramp 0..1023, back-to-back -> every bin = 1; second identical frame -> every bin = 1 again (read-clear verified).
- Frame alternating 5,5,5,7,5,7 with gaps in line_valid -> bin5=4, bin7=2 (forwarding hazards).
- COUNT_W=4 build, 20 pixels of value 3 -> bin3=15, sat_flag=1; next frame of 1 pixel -> sat_flag=0, bin3=1.
- Random out_ready throttling over a full readout -> out_data/out_bin stable while stalled, 1024 transfers in order; new frame_valid rise mid-readout -> frame_dropped single pulse, readout data unchanged.
- HISTO_SUM_EN defined, frame of 300 qualified pixels -> 1025 words, trailer out_bin=0x3FF, out_data=300, out_last only on trailer; assert reset mid-READOUT -> out_valid=0 immediately, INIT rerun, next frame counts start from zero.

Source files
------------

// File: rtl/histogram_engine.sv
// Per-frame pixel histogram: saturating bin counters in a read-modify-write RAM, streamed out with read-clear.
// Optional macro HISTO_SUM_EN appends a trailer word holding the frame's total qualified pixel count.
module histogram_engine #(
  parameter int PIXEL_W  = 10,
  parameter int BIN_BITS = 10,
  parameter int COUNT_W  = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PIXEL_W-1:0]  pixel_data,
  input  logic                frame_valid,
  input  logic                line_valid,
  output logic [COUNT_W-1:0]  out_data,
  output logic [BIN_BITS-1:0] out_bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                frame_dropped,
  output logic                sat_flag
);
  localparam int                  NUM_BINS = 2**BIN_BITS;
  localparam logic [BIN_BITS-1:0] LAST_BIN = '1;
  localparam logic [COUNT_W-1:0]  CNT_MAX  = '1;
`ifdef HISTO_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {INIT, IDLE, ACCUM, DRAIN, READOUT} state_e;

  // Reset asserts immediately, releases two clocks after the pin drops.
  logic rst_meta_q, rst_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_meta_q <= 1'b1;
      rst_q      <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_q      <= rst_meta_q;
    end
  end

  state_e              state_q, state_d;
  logic [BIN_BITS-1:0] ptr_q, ptr_d;
  logic                fv_prev_q;
  logic                s1_vld_q, s1_vld_d;
  logic [BIN_BITS-1:0] s1_bin_q, s1_bin_d;
  logic                lw_vld_q;
  logic [BIN_BITS-1:0] lw_bin_q;
  logic [COUNT_W-1:0]  lw_cnt_q;
  logic                out_valid_q, out_valid_d;
  logic [BIN_BITS-1:0] out_bin_q, out_bin_d;
  logic                out_last_q, out_last_d;
  logic                trailer_q, trailer_d;
  logic                busy_q, busy_d;
  logic                drop_q, drop_d;
  logic                sat_q, sat_d;

  logic [COUNT_W-1:0]  mem [NUM_BINS];
  logic                we;
  logic [BIN_BITS-1:0] waddr, raddr, pix_bin, nxt_bin;
  logic [COUNT_W-1:0]  wdata, rd_q, base, acc_cnt;
  logic                fv_rise, pix_ok, start, xfer, at_max;

  // Block RAM: one write port, one registered read port (read-before-write).
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_q <= mem[raddr];
  end

  assign pix_bin = pixel_data[PIXEL_W-1 -: BIN_BITS];
  assign fv_rise = frame_valid && !fv_prev_q;
  assign pix_ok  = frame_valid && line_valid &&
                   (state_q == ACCUM || (state_q == IDLE && fv_rise));
  assign xfer    = out_valid_q && out_ready;
  assign nxt_bin = out_bin_q + 1'b1;

  // The read for this stage was issued while the previous pixel was writing; forward that write.
  assign base    = (lw_vld_q && lw_bin_q == s1_bin_q) ? lw_cnt_q : rd_q;
  assign at_max  = (base == CNT_MAX);
  assign acc_cnt = at_max ? base : base + 1'b1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_bin_d   = out_bin_q;
    out_last_d  = out_last_q;
    trailer_d   = trailer_q;
    sat_d       = sat_q;
    start       = 1'b0;
    we          = s1_vld_q;
    waddr       = s1_bin_q;
    wdata       = acc_cnt;
    raddr       = pix_bin;
    s1_vld_d    = pix_ok;
    s1_bin_d    = pix_bin;
    if (s1_vld_q && at_max) sat_d = 1'b1;
    case (state_q)
      INIT: begin
        we    = 1'b1;
        waddr = ptr_q;
        wdata = '0;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_BIN) state_d = IDLE;
      end
      IDLE: begin
        if (fv_rise) begin
          state_d = ACCUM;
          start   = 1'b1;
          sat_d   = 1'b0;
        end
      end
      ACCUM: begin
        if (!frame_valid) begin
          state_d = DRAIN;
          ptr_d   = '0;
        end
      end
      DRAIN: begin
        raddr = '0;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q[0]) begin
          state_d     = READOUT;
          out_valid_d = 1'b1;
          out_bin_d   = '0;
          out_last_d  = 1'b0;
        end
      end
      READOUT: begin
        raddr = out_bin_q;
        if (xfer) begin
          if (!trailer_q) begin
            we    = 1'b1;
            waddr = out_bin_q;
            wdata = '0;
          end
          if (out_last_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_bin_d   = '0;
            trailer_d   = 1'b0;
          end else if (SUM_EN && out_bin_q == LAST_BIN) begin
            trailer_d  = 1'b1;
            out_last_d = 1'b1;
          end else begin
            out_bin_d  = nxt_bin;
            raddr      = nxt_bin;
            out_last_d = !SUM_EN && (nxt_bin == LAST_BIN);
          end
        end
      end
      default: state_d = INIT;
    endcase
    busy_d = (state_d != IDLE);
    drop_d = fv_rise && (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge rst_q) begin
    if (rst_q) begin
      state_q     <= INIT;
      ptr_q       <= '0;
      fv_prev_q   <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_bin_q    <= '0;
      lw_vld_q    <= 1'b0;
      lw_bin_q    <= '0;
      lw_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_last_q  <= 1'b0;
      trailer_q   <= 1'b0;
      busy_q      <= 1'b1;
      drop_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      fv_prev_q   <= frame_valid;
      s1_vld_q    <= s1_vld_d;
      s1_bin_q    <= s1_bin_d;
      lw_vld_q    <= s1_vld_q;
      lw_bin_q    <= s1_bin_q;
      lw_cnt_q    <= acc_cnt;
      out_valid_q <= out_valid_d;
      out_bin_q   <= out_bin_d;
      out_last_q  <= out_last_d;
      trailer_q   <= trailer_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
      sat_q       <= sat_d;
    end
  end

`ifdef HISTO_SUM_EN
  logic [COUNT_W-1:0] total_q, total_d;

  always_comb begin
    total_d = start ? '0 : total_q;
    if (pix_ok && total_d != CNT_MAX) total_d = total_d + 1'b1;
  end

  always_ff @(posedge clk or posedge rst_q) begin
    if (rst_q) total_q <= '0;
    else       total_q <= total_d;
  end

  assign out_data = !out_valid_q ? '0 : (trailer_q ? total_q : rd_q);
`else
  assign out_data = out_valid_q ? rd_q : '0;
`endif

  assign out_bin       = out_bin_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign busy          = busy_q;
  assign frame_dropped = drop_q;
  assign sat_flag      = sat_q;
endmodule

// File: tb/tb_histogram_engine.sv
// Bench for histogram_engine: random frames against a counting model, read-clear, throttling, drops, reset, saturation.
`timescale 1ns/1ps
module tb_histogram_engine;
  localparam int PW   = 10;
  localparam int BB   = 10;
  localparam int CW   = 24;
  localparam int NB   = 1 << BB;
  localparam int MAXC = (1 << CW) - 1;
`ifdef HISTO_SUM_EN
  localparam int NWORDS   = NB + 1;
  localparam int NWORDS_S = 17;
`else
  localparam int NWORDS   = NB;
  localparam int NWORDS_S = 16;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [PW-1:0] pixel_data = '0;
  logic          frame_valid = 1'b0, line_valid = 1'b0, out_ready = 1'b1;
  logic [CW-1:0] out_data;
  logic [BB-1:0] out_bin;
  logic          out_valid, out_last, busy, frame_dropped, sat_flag;

  logic [3:0] s_pix = '0;
  logic       s_fv = 1'b0, s_lv = 1'b0;
  logic [3:0] s_data, s_bin;
  logic       s_valid, s_last, s_busy, s_drop, s_sat;

  always #5 clk = ~clk;

  histogram_engine #(.PIXEL_W(PW), .BIN_BITS(BB), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .pixel_data(pixel_data), .frame_valid(frame_valid),
    .line_valid(line_valid), .out_data(out_data), .out_bin(out_bin), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .frame_dropped(frame_dropped),
    .sat_flag(sat_flag));

  histogram_engine #(.PIXEL_W(4), .BIN_BITS(4), .COUNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .pixel_data(s_pix), .frame_valid(s_fv),
    .line_valid(s_lv), .out_data(s_data), .out_bin(s_bin), .out_valid(s_valid),
    .out_ready(1'b1), .out_last(s_last), .busy(s_busy), .frame_dropped(s_drop),
    .sat_flag(s_sat));

  int tests = 0, fails = 0;
  int pq[$], gq[$];
  int exp_bins[NB];
  int exp_total;
  logic [CW-1:0] rq_data[$];
  logic [BB-1:0] rq_bin[$];
  logic          rq_last[$];
  int stable_err, bad_idx, drop_cnt = 0;
  bit timed_out;

  always @(negedge clk) if (frame_dropped) drop_cnt <= drop_cnt + 1;

  // Reference: histogram of the queued frame, saturating.
  task automatic model_frame();
    for (int b = 0; b < NB; b++) exp_bins[b] = 0;
    exp_total = 0;
    foreach (pq[i]) begin
      int b = pq[i] >> (PW - BB);
      if (exp_bins[b] < MAXC) exp_bins[b]++;
      if (exp_total < MAXC) exp_total++;
    end
  endtask

  function automatic int readout_errs();
    int e = 0;
    bad_idx = -1;
    for (int i = 0; i < rq_data.size(); i++) begin
      logic [CW-1:0] ed;
      logic [BB-1:0] eb;
      logic          el;
      if (i < NB) begin ed = CW'(exp_bins[i]); eb = BB'(i); end
      else begin ed = CW'(exp_total); eb = '1; end
      el = (i == NWORDS - 1);
      if (rq_data[i] !== ed || rq_bin[i] !== eb || rq_last[i] !== el) begin
        e++;
        if (bad_idx < 0) bad_idx = i;
      end
    end
    return e;
  endfunction

  task automatic build_random(input int n, input int lo, input int hi, input bit hazard);
    pq.delete(); gq.delete();
    for (int i = 0; i < n; i++) begin
      int v = hazard && ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) * 2 + 100
                                                    : $urandom_range(lo, hi);
      pq.push_back(v);
      gq.push_back($urandom_range(0, 9) < 7 ? 0 : $urandom_range(1, 2));
    end
  endtask

  task automatic drive_frame();
    @(negedge clk); frame_valid = 1'b1; line_valid = 1'b0;
    foreach (pq[i]) begin
      repeat (gq[i]) begin @(negedge clk); line_valid = 1'b0; pixel_data = PW'($urandom); end
      @(negedge clk); line_valid = 1'b1; pixel_data = PW'(pq[i]);
    end
    @(negedge clk); frame_valid = 1'b0; line_valid = 1'b0;
  endtask

  // Records every transfer; optionally raises a new frame on the transfer of word inject_at.
  task automatic collect(input bit rnd, input int inject_at, output int lat);
    int cyc = 0, inj_cyc = 0;
    bit stall = 0, done = 0, inj = 0;
    logic [CW-1:0] pd;
    logic [BB-1:0] pb;
    logic pl;
    rq_data.delete(); rq_bin.delete(); rq_last.delete();
    stable_err = 0; timed_out = 0; lat = -1;
    while (!done) begin
      @(negedge clk); cyc++;
      if (cyc > 30000) begin timed_out = 1; break; end
      if (stall && !(out_valid === 1'b1 && out_data === pd && out_bin === pb && out_last === pl))
        stable_err++;
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (out_valid && lat < 0) lat = cyc;
      if (out_valid && out_ready) begin
        if (rq_data.size() == inject_at) begin frame_valid = 1'b1; line_valid = 1'b1; inj = 1; end
        rq_data.push_back(out_data); rq_bin.push_back(out_bin); rq_last.push_back(out_last);
        if (out_last || rq_data.size() > NWORDS + 2) done = 1;
      end
      if (inj) begin
        inj_cyc++; pixel_data = PW'($urandom);
        if (inj_cyc == 40) begin frame_valid = 1'b0; line_valid = 1'b0; end
      end
      stall = out_valid && !out_ready; pd = out_data; pb = out_bin; pl = out_last;
    end
    out_ready = 1'b1;
  endtask

  task automatic check_readout(input string name);
    int e = readout_errs();
    tests++;
    if (timed_out !== 1'b0 || rq_data.size() !== NWORDS) begin
      fails++; $display("FAIL %s_count: got %0d words (timeout=%0d) expected %0d", name, rq_data.size(), timed_out, NWORDS);
    end
    tests++;
    if (e !== 0) begin
      fails++; $display("FAIL %s_data: %0d bad words, first idx %0d data %0d bin %0d last %0d", name, e, bad_idx,
                        rq_data[bad_idx], rq_bin[bad_idx], rq_last[bad_idx]);
    end
  endtask

  task automatic test_reset();
    int cyc = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({out_valid, out_last, busy, frame_dropped, sat_flag} !== 5'b00100 || out_data !== '0 || out_bin !== '0) begin
      fails++; $display("FAIL reset_outputs: got v%b l%b b%b d%b s%b data %0d bin %0d expected v0 l0 b1 d0 s0 0 0",
                        out_valid, out_last, busy, frame_dropped, sat_flag, out_data, out_bin);
    end
    reset = 1'b0;
    while (busy !== 1'b0 && cyc < 3000) begin @(negedge clk); cyc++; end
    tests++;
    if (cyc < NB || cyc > NB + 8) begin
      fails++; $display("FAIL init_length: got %0d cycles expected %0d..%0d", cyc, NB, NB + 8);
    end
  endtask

  task automatic test_zero_frame();
    int lat;
    pq.delete(); gq.delete();
    for (int i = 0; i < 16; i++) begin pq.push_back(0); gq.push_back(0); end
    model_frame(); drive_frame(); collect(0, -1, lat);
    check_readout("zero_frame");
    tests++;
    if (rq_data.size() > 0 && rq_data[0] !== CW'(16)) begin
      fails++; $display("FAIL bin0: got %0d expected 16", rq_data[0]);
    end
    tests++;
    if (lat < 1 || lat > 3) begin fails++; $display("FAIL first_word_latency: got %0d expected 1..3", lat); end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_ramp();
    int lat;
    for (int f = 0; f < 2; f++) begin
      pq.delete(); gq.delete();
      for (int i = 0; i < NB; i++) begin pq.push_back(i); gq.push_back(0); end
      model_frame(); drive_frame(); collect(0, -1, lat);
      check_readout(f == 0 ? "ramp1" : "ramp2");
    end
  endtask

  task automatic test_hazard();
    int lat;
    pq = '{5, 5, 5, 7, 5, 7};
    gq = '{0, 0, 2, 0, 1, 0};
    model_frame(); drive_frame(); collect(0, -1, lat);
    check_readout("hazard");
    tests++;
    if (rq_data.size() > 7 && (rq_data[5] !== CW'(4) || rq_data[7] !== CW'(2))) begin
      fails++; $display("FAIL hazard_bins: got bin5=%0d bin7=%0d expected 4 2", rq_data[5], rq_data[7]);
    end
    for (int f = 0; f < 3; f++) begin
      build_random($urandom_range(50, 400), 96, 111, 1'b1);
      model_frame(); drive_frame(); collect(0, -1, lat);
      check_readout("random_hazard");
    end
  endtask

  task automatic test_throttle_drop();
    int lat, d0;
    build_random(500, 0, NB - 1, 1'b1);
    model_frame(); drive_frame();
    d0 = drop_cnt;
    collect(1, 500, lat);
    repeat (2) @(negedge clk);
    check_readout("throttle");
    tests++;
    if (stable_err !== 0) begin fails++; $display("FAIL stall_stable: got %0d changes expected 0", stable_err); end
    tests++;
    if (drop_cnt - d0 !== 1) begin fails++; $display("FAIL drop_mid_readout: got %0d pulses expected 1", drop_cnt - d0); end
  endtask

  task automatic test_last_collision();
    int lat, d0, vis = 0;
    build_random(100, 0, NB - 1, 1'b0);
    model_frame(); drive_frame();
    d0 = drop_cnt;
    collect(0, NWORDS - 1, lat);
    repeat (5) @(negedge clk);
    frame_valid = 1'b0; line_valid = 1'b0;
    repeat (10) begin @(negedge clk); if (out_valid || busy) vis++; end
    check_readout("collision");
    tests++;
    if (drop_cnt - d0 !== 1) begin fails++; $display("FAIL drop_on_last: got %0d pulses expected 1", drop_cnt - d0); end
    tests++;
    if (vis !== 0) begin fails++; $display("FAIL no_frame_after_drop: got %0d active cycles expected 0", vis); end
  endtask

  task automatic test_sum();
    int lat;
    build_random(300, 0, NB - 1, 1'b0);
    model_frame(); drive_frame(); collect(0, -1, lat);
    check_readout("sum_frame");
`ifdef HISTO_SUM_EN
    tests++;
    if (rq_data.size() > NB && (rq_bin[NB] !== '1 || rq_data[NB] !== CW'(300) || rq_last[NB] !== 1'b1)) begin
      fails++; $display("FAIL trailer: got bin %0d data %0d last %b expected %0d 300 1", rq_bin[NB], rq_data[NB], rq_last[NB], NB - 1);
    end
`endif
  endtask

  task automatic test_mid_reset();
    int cyc = 0, lat;
    build_random(200, NB / 2, NB - 1, 1'b0);
    model_frame(); drive_frame();
    while (out_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL reset_mid_readout: got valid %b busy %b expected 0 1", out_valid, busy);
    end
    @(negedge clk); reset = 1'b0;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 3000) begin @(negedge clk); cyc++; end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reinit_done: got busy %b expected 0", busy); end
    build_random(50, 0, NB / 2 - 1, 1'b0);
    model_frame(); drive_frame(); collect(0, -1, lat);
    check_readout("after_reset");
  endtask

  task automatic test_saturation();
    for (int f = 0; f < 2; f++) begin
      int n = (f == 0) ? 20 : 1;
      int words = 0, c3 = -1, others = 0, trailer = -1, cyc = 0, exp = (n > 15) ? 15 : n;
      logic sat_seen = 1'bx;
      @(negedge clk); s_fv = 1'b1;
      for (int i = 0; i < n; i++) begin @(negedge clk); s_lv = 1'b1; s_pix = 4'd3; end
      @(negedge clk); s_fv = 1'b0; s_lv = 1'b0;
      while (words < NWORDS_S && cyc < 200) begin
        @(negedge clk); cyc++;
        if (s_valid) begin
          if (words == 0) sat_seen = s_sat;
          if (words < 16 && s_bin !== 4'(words)) others++;
          if (words == 3) c3 = int'(s_data);
          else if (words < 16 && s_data !== 4'd0) others++;
          else if (words == 16) trailer = int'(s_data);
          words++;
        end
      end
      tests++;
      if (words !== NWORDS_S || c3 !== exp || others !== 0) begin
        fails++; $display("FAIL sat_bins: got words %0d bin3 %0d bad %0d expected %0d %0d 0", words, c3, others, NWORDS_S, exp);
      end
      tests++;
      if (sat_seen !== (n > 15)) begin fails++; $display("FAIL sat_flag: got %b expected %b", sat_seen, n > 15); end
`ifdef HISTO_SUM_EN
      tests++;
      if (trailer !== exp) begin fails++; $display("FAIL sat_total: got %0d expected %0d", trailer, exp); end
`endif
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_ramp();
    test_hazard();
    test_throttle_drop();
    test_last_collision();
    test_sum();
    test_saturation();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
